// File: rtl/bridge_pkg.sv
// Shared types and constants for the Harvard-CPU to Avalon-MM bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECIDE,
    DATA,
    COMMIT,
    HALT,
    ERR
  } state_t;

  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/harvard_bus_bridge_if.sv
// Avalon-MM master bundle: the bridge drives the master side, memory the slave side.
interface harvard_bus_bridge_if;
  import bridge_pkg::*;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// Counts consecutive stalled cycles of one bus transfer; expired flags the last allowed one.
module bus_timeout_counter
  import bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Fires on the stall cycle that would bring the count up to TIMEOUT.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = enable && (count_reg == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/harvard_bus_bridge.sv
// Serialises a Harvard CPU's instruction and data ports onto one Avalon-MM master,
// releasing the CPU for one clock per instruction once its memory traffic is done.
module harvard_bus_bridge
  import bridge_pkg::*;
#(
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_active,
  output logic                  cpu_clk_enable,
  input  logic [31:0]           cpu_instr_address,
  output logic [31:0]           cpu_instr_readdata,
  input  logic [31:0]           cpu_data_address,
  input  logic                  cpu_data_read,
  input  logic                  cpu_data_write,
  input  logic [31:0]           cpu_data_writedata,
  output logic [31:0]           cpu_data_readdata,
  output logic                  bus_error,
  harvard_bus_bridge_if.master  avm
);

  state_t      state_reg;
  logic [31:0] instr_reg;
  logic [31:0] data_reg;
  logic        error_reg;
  logic        waiting;
  logic        expired;
  logic        data_is_read;
  logic        unused_bits;

  assign waiting      = ((state_reg == FETCH) || (state_reg == DATA)) && avm.avm_waitrequest;
  assign data_is_read = cpu_data_read && !cpu_data_write;
  // Address LSBs and the informational reset vector play no part in the logic.
  assign unused_bits  = ^{cpu_instr_address[1:0], cpu_data_address[1:0], RESET_VECTOR};

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (waiting),
    .clear   (!waiting),
    .expired (expired)
  );

  // Bus drive is decoded from the registered state; the CPU's address/data inputs
  // cannot move while it is held, so the request stays stable through any stall.
  // Gating with reset makes the strobes drop the instant reset is asserted.
  always_comb begin
    avm.avm_byteenable = BYTEEN_ALL;
    avm.avm_read       = 1'b0;
    avm.avm_write      = 1'b0;
    avm.avm_address    = '0;
    avm.avm_writedata  = '0;
    if (reset) begin
      case (state_reg)
        FETCH: begin
          avm.avm_read    = 1'b1;
          avm.avm_address = word_align(cpu_instr_address);
        end
        DATA: begin
          avm.avm_read      = data_is_read;
          avm.avm_write     = cpu_data_write;
          avm.avm_address   = word_align(cpu_data_address);
          avm.avm_writedata = cpu_data_writedata;
        end
        default: ;
      endcase
    end
  end

  assign cpu_clk_enable     = (state_reg == COMMIT);
  assign cpu_instr_readdata = instr_reg;
  assign cpu_data_readdata  = data_reg;
  assign bus_error          = error_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      instr_reg <= '0;
      data_reg  <= '0;
      error_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (expired) begin
            error_reg <= 1'b1;
            state_reg <= ERR;
          end else if (!avm.avm_waitrequest) begin
            instr_reg <= avm.avm_readdata;
            state_reg <= cpu_active ? DECIDE : HALT;
          end
        end
        DECIDE: begin
          // A simultaneous load and store is a CPU fault: the store wins.
          if (cpu_data_read && cpu_data_write) begin
            error_reg <= 1'b1;
          end
          state_reg <= (cpu_data_read || cpu_data_write) ? DATA : COMMIT;
        end
        DATA: begin
          if (expired) begin
            error_reg <= 1'b1;
            state_reg <= ERR;
          end else if (!avm.avm_waitrequest) begin
            if (data_is_read) begin
              data_reg <= avm.avm_readdata;
            end
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          state_reg <= cpu_active ? FETCH : HALT;
        end
        default: begin
          state_reg <= state_reg;
        end
      endcase
    end
  end

endmodule

// File: doc/harvard_bus_bridge.md
Name: harvard_bus_bridge

Overview:
- Sits between the Harvard CPU's two combinational memory ports and a single Avalon-MM master port with waitrequest.
- Per CPU instruction: fetches the instruction word, then performs at most one data access, then pulses cpu_clk_enable for exactly one cycle so the CPU commits.
- Data writes are issued only on the bus, never through the CPU's single-cycle write path.
- Lets the existing CPU run against variable-latency shared memory.

Parameters:
- TIMEOUT, 255, max waitrequest cycles per bus transfer before error; 0 disables the timeout.
- RESET_VECTOR, 32'hBFC00000, informational only; the bridge does not drive the PC.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_active  in  1  CPU active flag; 0 means the CPU has halted.
- cpu_clk_enable  out  1  one-cycle commit pulse to the CPU's clk_enable.
- cpu_instr_address  in  32  fetch address from the CPU.
- cpu_instr_readdata  out  32  latched instruction word.
- cpu_data_address  in  32  data address from the CPU.
- cpu_data_read  in  1  CPU load request.
- cpu_data_write  in  1  CPU store request.
- cpu_data_writedata  in  32  store data.
- cpu_data_readdata  out  32  latched load data.
- avm_address  out  32  bus byte address, always word-aligned (bits [1:0] = 0).
- avm_read  out  1  bus read.
- avm_write  out  1  bus write.
- avm_writedata  out  32  bus write data.
- avm_byteenable  out  4  constant 4'b1111.
- avm_readdata  in  32  bus read data.
- avm_waitrequest  in  1  slave stall.
- bus_error  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, async), all outputs 0 except avm_byteenable:
  - state=FETCH; cpu_instr_readdata, cpu_data_readdata, bus_error, cpu_clk_enable, avm_read, avm_write = 0.
  - Wait counter = 0.
- FETCH:
  - avm_read=1, avm_address={cpu_instr_address[31:2],2'b00}.
  - Hold until avm_waitrequest=0; that cycle latch avm_readdata into cpu_instr_readdata.
  - Next state is DATA if the request decoded from the latched instruction (cpu_data_read|cpu_data_write, sampled the following cycle) is set, else COMMIT.
  - Implementation: FETCH always goes to DECIDE (1 cycle, no bus activity). DECIDE goes to DATA or COMMIT.
- DATA:
  - avm_address={cpu_data_address[31:2],2'b00}.
  - avm_write=cpu_data_write, avm_writedata=cpu_data_writedata, avm_read=cpu_data_read & ~cpu_data_write.
  - Bus outputs must hold stable while avm_waitrequest=1.
  - On avm_waitrequest=0: latch avm_readdata into cpu_data_readdata (reads only), then go to COMMIT.
- COMMIT:
  - cpu_clk_enable=1 for exactly this cycle, with no bus activity.
  - Next state is HALT if cpu_active=0 (sampled in COMMIT), else FETCH.
- HALT:
  - All bus strobes 0, cpu_clk_enable=0; terminal until reset.
- Simultaneous cpu_data_read & cpu_data_write in DECIDE:
  - Write performed, read suppressed, bus_error set (sticky).
- Timeout:
  - Counter increments each cycle with waitrequest=1 in FETCH/DATA and clears on transfer acceptance.
  - When the counter reaches TIMEOUT (TIMEOUT≠0): bus_error=1, drop strobes, go to ERR. ERR is terminal like HALT.
- cpu_active=0 observed in FETCH (CPU halted before first commit): finish any in-flight transfer, then go to HALT without a commit.
- Reset asserted mid-transfer: strobes drop asynchronously. No partial write is retried after reset.
- Latency with zero-wait memory:
  - Non-memory instruction: 3 cycles (FETCH, DECIDE, COMMIT).
  - Load/store: 4 cycles.

Decomposition:
- Shared package bridge_pkg:
  - typedef enum of states FETCH, DECIDE, DATA, COMMIT, HALT, ERR.
  - BYTEEN_ALL=4'b1111.
- One sub-module: bus_timeout_counter (enable, clear, TIMEOUT param, expired output).

Test Plan:
- Zero-wait memory, instr 32'h24020005 (addiu v0,zero,5) at 0xBFC00000:
  - avm_read at 0xBFC00000 for 1 cycle, cpu_instr_readdata=32'h24020005.
  - cpu_clk_enable pulses in cycle 3, no avm_write.
- Store sw with data_address 0x00001006, writedata 0xDEADBEEF, waitrequest held 2 cycles:
  - avm_write=1 for 3 cycles, address 0x00001004, data stable throughout.
  - Exactly one commit pulse.
- Load with avm_readdata 0x12345678 and 1 wait cycle:
  - cpu_data_readdata=0x12345678 before the commit pulse.
  - avm_read deasserts the cycle after acceptance.
- TIMEOUT=4, waitrequest stuck 1 during FETCH:
  - bus_error=1 after 4 wait cycles, strobes drop, state ERR, no cpu_clk_enable ever.
- cpu_active falls before a COMMIT cycle:
  - after that commit, no further avm_read.
  - cpu_clk_enable stays 0 for 20 cycles.
- cpu_data_read=cpu_data_write=1 in DECIDE:
  - only avm_write issued, bus_error=1.
- Reset asserted mid-DATA write:
  - avm_write=0 immediately (async), all outputs at reset values.
  - After release, the first bus access is a FETCH read.
